pipe_muldiv: RTL
================

Name: pipe_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage pipeline, driven from the EXE stage. Handles MULT, MULTU, DIV and DIVU on WIDTH-bit operands. Uses radix-2 shift-add for multiply and restoring division for divide. Asserts busy so the ID-stage interlock stalls any mfhi/mflo or new mul/div while an operation is in flight.

Parameters:
WIDTH, 32, operand width and HI/LO width; legal values are 8 to 64.
CNTW, $clog2(WIDTH+1), width of the iteration counter; derived, never overridden.

Ports:
clk    in   1       pipeline clock
rst    in   1       asynchronous reset, active-high
start  in   1       issue pulse from EXE; sampled only in IDLE
op     in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a      in   WIDTH   rs operand (multiplicand or dividend)
b      in   WIDTH   rt operand (multiplier or divisor)
flush  in   1       abort the in-flight operation (branch/exception kill)
mthi   in   1       write hi from wdata
mtlo   in   1       write lo from wdata
wdata  in   WIDTH   data for mthi/mtlo
busy   out  1       operation in flight; drives the ID stall
done   out  1       one-cycle pulse when the result is committed
hi     out  WIDTH   HI register
lo     out  WIDTH   LO register

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0; internal accumulators=0.
- States:
  - IDLE -> CALC on start.
  - CALC holds for WIDTH cycles, counter runs WIDTH-1 down to 0; at counter=0 -> FIX.
  - FIX -> IDLE after one cycle.
- Start capture (edge where start=1 in IDLE):
  - Latch op.
  - For signed ops, latch |a| and |b| plus the result signs. Quotient is negative iff the operand signs differ. Remainder sign follows the dividend.
- Iteration: one step per CALC cycle, either a conditional add and shift or a trial subtract and shift.
- FIX cycle:
  - Apply the sign correction (two's-complement negate of the 2*WIDTH product, or of the quotient/remainder separately).
  - On the exit edge, write hi/lo and set done=1 for exactly one cycle.
- Latency: start sampled at edge 0. busy=1 during cycles 1..WIDTH+1. At edge WIDTH+2, hi/lo are updated and done=1 while busy=0. Latency is identical for all ops and operand values.
- busy is a registered decode of state != IDLE. It is never high in the same cycle as done.
- Result mapping:
  - Multiply: hi = upper WIDTH bits of the product, lo = lower WIDTH bits.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b=0): still runs the full latency; result is lo = all ones, hi = a (raw operand, no sign fix).
- Signed overflow (DIV of MIN by -1): lo = MIN, hi = 0, from truncation of the magnitude result. No trap.
- start while busy: ignored. The pipeline interlock guarantees this never happens; it must not corrupt the in-flight op.
- flush:
  - In CALC or FIX: return to IDLE next edge; hi/lo keep prior values; no done pulse.
  - In IDLE: no effect.
  - flush and start on the same edge in IDLE: the start is dropped.
- mthi/mtlo:
  - Honoured only in IDLE, and only when start=0 that cycle. Writes wdata on that edge.
  - Ignored while busy, and ignored on an accepted-start edge (start wins).
  - mthi and mtlo together write both registers.
- Reset mid-operation: immediate return to the reset values above; no done pulse.

Decomposition:
- Shared package pipe_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state typedef md_state_t {MD_IDLE, MD_CALC, MD_FIX};
  - the result constant for divide by zero.
- One natural sub-module, md_sign_fix: a combinational conditional negate for the WIDTH and 2*WIDTH paths, instantiated in FIX.
- The remaining datapath stays in pipe_muldiv.

Test Plan (WIDTH=32):
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge 0 -> busy during cycles 1..33; at edge 34 hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7 after 34 cycles. DIVU a=100 b=7 -> lo=14, hi=2.
5. Preload hi=0x11, lo=0x22 via mthi/mtlo. Start MULTU 5*5, then assert flush at cycle 10 -> busy=0 at edge 11, hi=0x11, lo=0x22, no done. Repeat with rst asserted at cycle 20 -> hi=lo=0, busy=0 immediately.
6. Collisions:
   - start together with mthi in IDLE -> mthi ignored; result as in case 1.
   - mtlo while busy -> lo unchanged until done.
   - second start while busy -> ignored; first result intact.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline multiply/divide unit: operation
// encodings, controller states and the divide-by-zero quotient pattern.
package pipe_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  // Quotient returned for a zero divisor; sliced down to the unit width.
  localparam logic [63:0] MD_DIVZ_QUO = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate used in the FIX cycle: one path for
// the full double-width product, two independent paths for quotient and
// remainder.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               neg_wide,
  input  logic [2*WIDTH-1:0] wide_in,
  output logic [2*WIDTH-1:0] wide_out,
  input  logic               neg_q,
  input  logic [WIDTH-1:0]   q_in,
  output logic [WIDTH-1:0]   q_out,
  input  logic               neg_r,
  input  logic [WIDTH-1:0]   r_in,
  output logic [WIDTH-1:0]   r_out
);

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Negate each path only when its result sign calls for it.
  always_comb begin
    wide_out = wide_in;
    q_out    = q_in;
    r_out    = r_in;
    if (neg_wide) begin
      wide_out = ~wide_in + ONE_2W;
    end else begin
      wide_out = wide_in;
    end
    if (neg_q) begin
      q_out = ~q_in + ONE_W;
    end else begin
      q_out = q_in;
    end
    if (neg_r) begin
      r_out = ~r_in + ONE_W;
    end else begin
      r_out = r_in;
    end
  end

endmodule

// File: rtl/pipe_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are converted to magnitudes at issue, iterated for WIDTH cycles
// (shift-add multiply or restoring divide), sign-corrected in one FIX
// cycle, and committed to HI/LO one edge later, when busy has dropped.
module pipe_muldiv
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]  CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]  CNT_INIT = CNTW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIVZ_Q   = MD_DIVZ_QUO[WIDTH-1:0];

  md_state_t state_r, state_n;

  logic [CNTW-1:0]    cnt_r;
  logic               is_div_r;
  logic               neg_lo_r;     // product sign (mul) or quotient sign (div)
  logic               neg_hi_r;     // remainder sign, follows the dividend
  logic               divz_r;
  logic [WIDTH-1:0]   a_raw_r;
  logic [WIDTH-1:0]   opnd_r;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_r;        // {partial product | remainder, multiplier | quotient}
  logic               busy_r;
  logic               done_r;
  logic               commit_r;
  logic [WIDTH-1:0]   res_hi_r, res_lo_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               signed_op_s, div_op_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               start_ok_s, mt_ok_s;
  logic [WIDTH-1:0]   acc_hi_s, acc_lo_s;
  logic [WIDTH:0]     add_s, rem_sh_s, trial_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] wide_fix_s;
  logic [WIDTH-1:0]   q_fix_s, r_fix_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  assign acc_hi_s = acc_r[2*WIDTH-1:WIDTH];
  assign acc_lo_s = acc_r[WIDTH-1:0];

  // Issue decode: operand magnitudes, signs and the accept/mt-write qualifiers.
  always_comb begin
    signed_op_s = (op == MD_MULT) || (op == MD_DIV);
    div_op_s    = (op == MD_DIV) || (op == MD_DIVU);
    a_neg_s     = signed_op_s && a[WIDTH-1];
    b_neg_s     = signed_op_s && b[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = ~a + ONE_W;
    end else begin
      a_mag_s = a;
    end
    if (b_neg_s) begin
      b_mag_s = ~b + ONE_W;
    end else begin
      b_mag_s = b;
    end
    // The commit cycle still reports busy, so nothing is accepted then.
    start_ok_s = (state_r == MD_IDLE) && !busy_r && start && !flush;
    mt_ok_s    = (state_r == MD_IDLE) && !busy_r && !start;
  end

  // One iteration step: conditional add-and-shift-right, or trial subtract
  // and shift-left with the quotient bit entering at the bottom.
  always_comb begin
    add_s    = {1'b0, acc_hi_s} + (acc_lo_s[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    rem_sh_s = {acc_hi_s, acc_lo_s[WIDTH-1]};
    trial_s  = rem_sh_s - {1'b0, opnd_r};
    if (is_div_r) begin
      if (!trial_s[WIDTH]) begin
        acc_step_s = {trial_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {rem_sh_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {add_s, acc_lo_s[WIDTH-1:1]};
    end
  end

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .neg_wide (neg_lo_r),
    .wide_in  (acc_r),
    .wide_out (wide_fix_s),
    .neg_q    (neg_lo_r),
    .q_in     (acc_lo_s),
    .q_out    (q_fix_s),
    .neg_r    (neg_hi_r),
    .r_in     (acc_hi_s),
    .r_out    (r_fix_s)
  );

  // Final HI/LO values: zero divisor bypasses the sign fix entirely.
  always_comb begin
    res_hi_s = ZERO_W;
    res_lo_s = ZERO_W;
    if (divz_r) begin
      res_hi_s = a_raw_r;
      res_lo_s = DIVZ_Q;
    end else if (is_div_r) begin
      res_hi_s = r_fix_s;
      res_lo_s = q_fix_s;
    end else begin
      res_hi_s = wide_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = wide_fix_s[WIDTH-1:0];
    end
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state: WIDTH CALC cycles, one FIX cycle, flush aborts to IDLE.
  always_comb begin
    state_n = state_r;
    case (state_r)
      MD_IDLE: begin
        if (start_ok_s) begin
          state_n = MD_CALC;
        end else begin
          state_n = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (flush) begin
          state_n = MD_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_n = MD_FIX;
        end else begin
          state_n = MD_CALC;
        end
      end
      MD_FIX: begin
        state_n = MD_IDLE;
      end
      default: begin
        state_n = MD_IDLE;
      end
    endcase
  end

  // Operand capture at issue and one iteration per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= CNT_ZERO;
      is_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      divz_r   <= 1'b0;
      a_raw_r  <= ZERO_W;
      opnd_r   <= ZERO_W;
      acc_r    <= {(2*WIDTH){1'b0}};
    end else if (start_ok_s) begin
      cnt_r    <= CNT_INIT;
      is_div_r <= div_op_s;
      neg_lo_r <= a_neg_s ^ b_neg_s;
      neg_hi_r <= div_op_s && a_neg_s;
      divz_r   <= div_op_s && (b == ZERO_W);
      a_raw_r  <= a;
      opnd_r   <= div_op_s ? b_mag_s : a_mag_s;
      acc_r    <= {ZERO_W, (div_op_s ? a_mag_s : b_mag_s)};
    end else if (state_r == MD_CALC) begin
      acc_r <= acc_step_s;
      cnt_r <= (cnt_r == CNT_ZERO) ? CNT_ZERO : (cnt_r - CNT_ONE);
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // busy follows the in-flight state one edge late, but flush drops it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_r != MD_IDLE) && !flush;
    end
  end

  // Hold the corrected result for one cycle so commit lands after busy falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_r <= 1'b0;
      res_hi_r <= ZERO_W;
      res_lo_r <= ZERO_W;
    end else if ((state_r == MD_FIX) && !flush) begin
      commit_r <= 1'b1;
      res_hi_r <= res_hi_s;
      res_lo_r <= res_lo_s;
    end else begin
      commit_r <= 1'b0;
    end
  end

  // Architectural HI/LO: result commit or mthi/mtlo writes while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r   <= ZERO_W;
      lo_r   <= ZERO_W;
      done_r <= 1'b0;
    end else if (commit_r) begin
      hi_r   <= res_hi_r;
      lo_r   <= res_lo_r;
      done_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      if (mt_ok_s && mthi) begin
        hi_r <= wdata;
      end
      if (mt_ok_s && mtlo) begin
        lo_r <= wdata;
      end
    end
  end

endmodule
